// File: rtl/gb_lcd_capture_if.sv
// rtl/gb_lcd_capture_if.sv - framebuffer write port between capture and framebuffer memory
interface gb_lcd_capture_if;
  logic        FB_WR;
  logic [13:0] FB_ADDR;
  logic [7:0]  FB_DATA;
  logic        FB_READY;

  modport master (output FB_WR, FB_ADDR, FB_DATA, input FB_READY);
  modport slave  (input FB_WR, FB_ADDR, FB_DATA, output FB_READY);
endinterface

// File: rtl/gb_lcd_capture.sv
// rtl/gb_lcd_capture.sv - PPU pixel capture into a double-buffered packed framebuffer
// Optional BGP palette mapping of captured pixels: define LCD_CAPTURE_PALETTE_EN.
module gb_lcd_capture #(
  parameter int LINE_PIXELS = 160,
  parameter int FRAME_LINES = 144,
  parameter int BANK_BYTES  = 5760
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LCD_ON,
  input  logic [1:0]       PPU_MODE,
  input  logic [1:0]       PX_IN,
  input  logic             PX_valid,
  input  logic [7:0]       BGP,
  gb_lcd_capture_if.master fb,
  output logic             DISP_BANK,
  output logic             FRAME_DONE,
  output logic             OVERRUN,
  input  logic             CLR_OVR
);
  localparam logic [1:0]  MODE_HBLANK = 2'd0;
  localparam logic [1:0]  MODE_VBLANK = 2'd1;
  localparam logic [1:0]  MODE_DRAW   = 2'd3;
  localparam logic [7:0]  X_END       = 8'(LINE_PIXELS);
  localparam logic [7:0]  Y_END       = 8'(FRAME_LINES);
  localparam logic [13:0] BANK_SIZE   = 14'(BANK_BYTES);

  typedef enum logic [1:0] {IDLE, LINE, FLUSH} state_t;

  state_t      state;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [7:0]  pack;
  logic [1:0]  prev_mode;
  logic        swap_pending;

  logic        accept;
  logic        complete;
  logic        flush_byte;
  logic        new_byte;
  logic        can_load;
  logic        drop;
  logic        draw_exit;
  logic        vblank_entry;
  logic [1:0]  px_col;
  logic [1:0]  pad_col;
  logic [7:0]  padded;
  logic [7:0]  byte_data;
  logic [13:0] byte_addr;

`ifdef LCD_CAPTURE_PALETTE_EN
  always_comb begin
    px_col = BGP[1:0];
    case (PX_IN)
      2'd1:    px_col = BGP[3:2];
      2'd2:    px_col = BGP[5:4];
      2'd3:    px_col = BGP[7:6];
      default: px_col = BGP[1:0];
    endcase
  end
  assign pad_col = BGP[1:0];
`else
  logic unused_bgp;
  assign unused_bgp = ^BGP;
  assign px_col     = PX_IN;
  assign pad_col    = 2'b00;
`endif

  // Pad a partial line-end byte so the earliest pixel still lands in bits [7:6].
  always_comb begin
    padded = pack;
    case (x[1:0])
      2'd1:    padded = {pack[1:0], pad_col, pad_col, pad_col};
      2'd2:    padded = {pack[3:0], pad_col, pad_col};
      2'd3:    padded = {pack[5:0], pad_col};
      default: padded = pack;
    endcase
  end

  assign accept       = PX_valid && LCD_ON && (PPU_MODE == MODE_DRAW) && (state != FLUSH)
                        && (x < X_END) && (y < Y_END);
  assign complete     = accept && (x[1:0] == 2'b11);
  assign flush_byte   = (state == FLUSH) && (x[1:0] != 2'b00);
  assign new_byte     = complete || flush_byte;
  assign can_load     = !fb.FB_WR || fb.FB_READY;
  assign drop         = LCD_ON && new_byte && !can_load;
  assign draw_exit    = (state == LINE) && (PPU_MODE != MODE_DRAW);
  assign vblank_entry = (PPU_MODE == MODE_VBLANK) && (prev_mode != MODE_VBLANK);
  assign byte_data    = complete ? {pack[5:0], px_col} : padded;
  assign byte_addr    = (DISP_BANK ? 14'd0 : BANK_SIZE) + ({6'd0, y} << 5) + ({6'd0, y} << 3)
                        + {8'd0, x[7:2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      x            <= 8'd0;
      y            <= 8'd0;
      pack         <= 8'd0;
      prev_mode    <= MODE_HBLANK;
      swap_pending <= 1'b0;
      fb.FB_WR     <= 1'b0;
      fb.FB_ADDR   <= 14'd0;
      fb.FB_DATA   <= 8'd0;
      DISP_BANK    <= 1'b0;
      FRAME_DONE   <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      prev_mode  <= PPU_MODE;
      FRAME_DONE <= 1'b0;
      if (drop) begin
        OVERRUN <= 1'b1;
      end else if (CLR_OVR) begin
        OVERRUN <= 1'b0;
      end

      if (!LCD_ON) begin
        state        <= IDLE;
        x            <= 8'd0;
        y            <= 8'd0;
        pack         <= 8'd0;
        swap_pending <= 1'b0;
        fb.FB_WR     <= 1'b0;
      end else begin
        if (fb.FB_WR && fb.FB_READY) begin
          fb.FB_WR <= 1'b0;
        end
        if (new_byte && can_load) begin
          fb.FB_WR   <= 1'b1;
          fb.FB_ADDR <= byte_addr;
          fb.FB_DATA <= byte_data;
        end
        if (accept) begin
          pack <= {pack[5:0], px_col};
          x    <= x + 8'd1;
        end

        case (state)
          IDLE:    if (PPU_MODE == MODE_DRAW) state <= LINE;
          LINE:    if (draw_exit) state <= FLUSH;
          FLUSH: begin
            state <= IDLE;
            x     <= 8'd0;
            pack  <= 8'd0;
            y     <= swap_pending ? 8'd0 : ((y < Y_END) ? y + 8'd1 : y);
          end
          default: state <= IDLE;
        endcase

        // The swap waits for the last queued byte and any pending line flush.
        if (vblank_entry) begin
          swap_pending <= 1'b1;
          if (!draw_exit) y <= 8'd0;
        end else if (swap_pending && (state != FLUSH) && !draw_exit && !new_byte && can_load) begin
          DISP_BANK    <= ~DISP_BANK;
          FRAME_DONE   <= 1'b1;
          swap_pending <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_gb_lcd_capture.sv
// tb/tb_gb_lcd_capture.sv - scoreboard bench for gb_lcd_capture
// Expected framebuffer writes are queued by stimulus and popped by a negedge monitor.
module tb_gb_lcd_capture;
  localparam logic [1:0] M_HB = 2'd0, M_VB = 2'd1, M_SCAN = 2'd2, M_DRAW = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       LCD_ON = 1'b0;
  logic [1:0] PPU_MODE = M_HB;
  logic [1:0] PX_IN = 2'd0;
  logic       PX_valid = 1'b0;
  logic [7:0] BGP = 8'hE4;
  logic       CLR_OVR = 1'b0;
  logic       DISP_BANK;
  logic       FRAME_DONE;
  logic       OVERRUN;

  gb_lcd_capture_if fb();

  gb_lcd_capture dut (
    .clk(clk), .rst(rst), .LCD_ON(LCD_ON), .PPU_MODE(PPU_MODE), .PX_IN(PX_IN),
    .PX_valid(PX_valid), .BGP(BGP), .fb(fb), .DISP_BANK(DISP_BANK),
    .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN), .CLR_OVR(CLR_OVR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          writes = 0;
  int          fd_count = 0;
  logic        st_prev = 1'b0;
  logic        st_lcd = 1'b0;
  logic [13:0] st_addr = 14'd0;
  logic [7:0]  st_data = 8'd0;
  logic [7:0]  stall_tab [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [13:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic end_line();
    PX_valid = 1'b0;
    PPU_MODE = M_HB;
    repeat (4) step();
  endtask

  // Pattern 0,1,2,3 repeating packs to 8'h1B at every byte.
  task automatic pattern_line(input int npx, input int yline, input logic [13:0] base,
                              input bit stall_end);
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    for (int i = 0; i < npx; i++) begin
      PX_IN = 2'(i % 4);
      PX_valid = 1'b1;
      if ((i % 4 == 3) && (i < 160)) push_exp(base + 14'(yline * 40 + i / 4), 8'h1B);
      step();
    end
    if (stall_end) fb.FB_READY = 1'b0;
    end_line();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (st_prev && st_lcd) begin
        check("hold_wr", fb.FB_WR, 1);
        check("hold_addr", fb.FB_ADDR, st_addr);
        check("hold_data", fb.FB_DATA, st_data);
      end
      if (fb.FB_WR && fb.FB_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr %0d data %0h with empty queue", fb.FB_ADDR, fb.FB_DATA);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", fb.FB_ADDR, e.addr);
          check("wr_data", fb.FB_DATA, e.data);
        end
        writes++;
      end
      st_prev = fb.FB_WR && !fb.FB_READY;
      st_lcd  = LCD_ON;
      st_addr = fb.FB_ADDR;
      st_data = fb.FB_DATA;
      if (FRAME_DONE) fd_count++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    fb.FB_READY = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fb_wr", fb.FB_WR, 0);
    check("rst_fb_addr", fb.FB_ADDR, 0);
    check("rst_fb_data", fb.FB_DATA, 0);
    check("rst_disp_bank", DISP_BANK, 0);
    check("rst_frame_done", FRAME_DONE, 0);
    check("rst_overrun", OVERRUN, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    LCD_ON = 1'b1;
    repeat (2) step();

    // Line 0: 162 pixels, the last two overshoot and must vanish.
    w0 = writes;
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    for (int i = 0; i < 162; i++) begin
      PX_IN = 2'(i % 4);
      PX_valid = 1'b1;
      if ((i % 4 == 3) && (i < 160)) push_exp(14'(5760 + i / 4), 8'h1B);
      step();
      if (i == 3) begin
        @(negedge clk);
        check("latency_wr", fb.FB_WR, 1);
        check("latency_addr", fb.FB_ADDR, 5760);
      end
    end
    end_line();
    check("line0_writes", writes - w0, 40);
    check("line0_overrun", OVERRUN, 0);

    // Line 1: FB_READY low for pixels 5..12, byte 2 is dropped.
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    for (int i = 0; i < 160; i++) begin
      PX_IN = 2'((i / 4) % 4);
      PX_valid = 1'b1;
      fb.FB_READY = !((i >= 5) && (i <= 12));
      if ((i % 4 == 3) && (i / 4 != 2)) push_exp(14'(5800 + i / 4), stall_tab[(i / 4) % 4]);
      step();
      if (i == 12) begin
        @(negedge clk);
        check("stall_held_wr", fb.FB_WR, 1);
        check("stall_held_addr", fb.FB_ADDR, 5801);
        check("stall_held_data", fb.FB_DATA, 8'h55);
      end
    end
    fb.FB_READY = 1'b1;
    end_line();
    check("overrun_set", OVERRUN, 1);
    CLR_OVR = 1'b1;
    step();
    CLR_OVR = 1'b0;
    @(negedge clk);
    check("overrun_cleared", OVERRUN, 0);

    // Line 2: six pixels of colour 3, second byte padded with colour 0.
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    push_exp(14'd5840, 8'hFF);
    push_exp(14'd5841, 8'hF0);
    for (int i = 0; i < 6; i++) begin
      PX_IN = 2'd3;
      PX_valid = 1'b1;
      step();
    end
    end_line();

    for (int yl = 3; yl < 144; yl++) pattern_line(160, yl, 14'd5760, yl == 143);

    // Last byte still stalled at V-blank entry: the swap must wait for it.
    PPU_MODE = M_VB;
    repeat (4) step();
    @(negedge clk);
    check("vb_bank_wait", DISP_BANK, 0);
    check("vb_fd_wait", fd_count, 0);
    fb.FB_READY = 1'b1;
    repeat (10) step();
    check("vb_bank_swap", DISP_BANK, 1);
    check("vb_fd_single", fd_count, 1);
    check("frame0_queue", exp_q.size(), 0);

    pattern_line(8, 0, 14'd0, 1'b0);

    // LCD off with a write pending: abandon it, keep the bank.
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    fb.FB_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PX_IN = 2'(i);
      PX_valid = 1'b1;
      step();
    end
    PX_valid = 1'b0;
    LCD_ON = 1'b0;
    @(negedge clk);
    check("lcd_pending_wr", fb.FB_WR, 1);
    step();
    @(negedge clk);
    check("lcd_off_wr_drop", fb.FB_WR, 0);
    PPU_MODE = M_HB;
    repeat (2) step();
    check("lcd_off_bank", DISP_BANK, 1);
    check("lcd_off_no_fd", fd_count, 1);
    LCD_ON = 1'b1;
    fb.FB_READY = 1'b1;
    step();
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    push_exp(14'd0, 8'hE4);
    for (int i = 0; i < 4; i++) begin
      PX_IN = 2'(3 - i);
      PX_valid = 1'b1;
      step();
    end
    end_line();

`ifdef LCD_CAPTURE_PALETTE_EN
    BGP = 8'h1B;
    PPU_MODE = M_SCAN;
    step();
    PPU_MODE = M_DRAW;
    push_exp(14'd40, 8'hE4);
    for (int i = 0; i < 4; i++) begin
      PX_IN = 2'(i);
      PX_valid = 1'b1;
      step();
    end
    end_line();
    BGP = 8'hE4;
`endif

    repeat (5) step();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_overrun", OVERRUN, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
